// File: rtl/jk_bank_driver.sv
// Purpose: drives J/K of an external WIDTH-bit jk_ff bank to reach a requested value, verifies Q, retries.
// Latency: accept at cycle 0, J/K in cycle 1, done/err pulse in cycle SETTLE+3 (+SETTLE+2 per retry).
// Backpressure: req_ready high only in IDLE; a requester holds req_valid until accepted.
//
// Ports:
//   clk, rst            clock shared with the bank; asynchronous active-high reset
//   req_valid/req_ready request handshake
//   req_mode, req_data  00 load data, 01 toggle mask, 10 clear, 11 set
//   q_in                Q read back from the bank
//   j_out, k_out        registered J/K drive to the bank
//   busy, done, err     status; done/err are one-cycle pulses
//   err_cnt             (only with JK_ERR_CNT_EN) saturating count of failed checks
//
// Optional feature macro: JK_ERR_CNT_EN
module jk_bank_driver #(
  parameter int WIDTH     = 8,
  parameter int SETTLE    = 1,
  parameter int MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_mode,
  input  logic [WIDTH-1:0] req_data,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             busy,
  output logic             done,
  output logic             err
`ifdef JK_ERR_CNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_DONE_OK,
    S_DONE_ERR
  } state_t;

  localparam logic [1:0] MODE_LOAD   = 2'b00;
  localparam logic [1:0] MODE_TOGGLE = 2'b01;
  localparam logic [1:0] MODE_CLEAR  = 2'b10;
  localparam logic [1:0] MODE_SET    = 2'b11;

  // Counter preload: SETTLE cycles spent in S_SETTLE, counting down to zero.
  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE - 1);
  localparam logic [2:0] RETRY_MAX   = 3'(MAX_RETRY);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [2:0]       retry_q, retry_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             chk_fail;
  logic [WIDTH-1:0] acc_exp;

  // Target value for a request being accepted; toggle uses Q as seen at acceptance.
  always_comb begin
    acc_exp = '0;
    case (req_mode)
      MODE_LOAD:   acc_exp = req_data;
      MODE_TOGGLE: acc_exp = q_in ^ req_data;
      MODE_CLEAR:  acc_exp = '0;
      MODE_SET:    acc_exp = '1;
      default:     acc_exp = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    j_d      = '0;
    k_d      = '0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    retry_d  = retry_q;
    cnt_d    = cnt_q;
    chk_fail = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          exp_d   = acc_exp;
          state_d = S_DRIVE;
          if (req_mode == MODE_TOGGLE) begin
            // First toggle drive uses the bank's own J=K=1 toggle behaviour.
            j_d = req_data;
            k_d = req_data;
          end else begin
            j_d = ~q_in & acc_exp;
            k_d = q_in & ~acc_exp;
          end
        end
      end
      S_DRIVE: begin
        // The bank samples J/K at the edge ending this state.
        state_d = S_SETTLE;
        cnt_d   = SETTLE_INIT;
      end
      S_SETTLE: begin
        if (cnt_q == 4'd0) state_d = S_CHECK;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_CHECK: begin
        if (q_in == exp_q) begin
          state_d = S_DONE_OK;
          done_d  = 1'b1;
        end else begin
          chk_fail = 1'b1;
          if (retry_q < RETRY_MAX) begin
            // Retries always use set/reset excitation from the present Q.
            retry_d = retry_q + 3'd1;
            state_d = S_DRIVE;
            j_d     = ~q_in & exp_q;
            k_d     = q_in & ~exp_q;
          end else begin
            state_d = S_DONE_ERR;
            err_d   = 1'b1;
          end
        end
      end
      S_DONE_OK, S_DONE_ERR: begin
        retry_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      exp_q   <= '0;
      j_q     <= '0;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      retry_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      j_q     <= j_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      retry_q <= retry_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef JK_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Counts every failed check, retried or final; sticks at 255.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (chk_fail && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_chk_fail;
  assign unused_chk_fail = chk_fail;
`endif

  assign req_ready = (state_q == S_IDLE);
  assign j_out     = j_q;
  assign k_out     = k_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_jk_bank_driver.sv
// Purpose: self-checking bench for jk_bank_driver with a behavioural JK bank and stuck-at-0 readback faults.
// Latency: expectations follow accept@0, J/K@1, pulse@SETTLE+3 (+SETTLE+2 per retry).
// Backpressure: requests are presented only when req_ready is seen high; one sequence holds valid.
module tb_jk_bank_driver;
  localparam int WIDTH     = 8;
  localparam int SETTLE    = 1;
  localparam int MAX_RETRY = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_mode;
  logic [7:0] req_data;
  logic [7:0] q_in;
  logic [7:0] j_out, k_out;
  logic       busy, done, err;
`ifdef JK_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  // Bank model: internal flops, readback optionally stuck at 0 per bit.
  logic [7:0] bank  = 8'h00;
  logic [7:0] stuck = 8'h00;
  assign q_in = bank & ~stuck;

  always @(posedge clk) bank <= (j_out & ~bank) | (~k_out & bank);

  always #5 clk = ~clk;

  jk_bank_driver #(.WIDTH(WIDTH), .SETTLE(SETTLE), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_mode(req_mode), .req_data(req_data),
    .q_in(q_in), .j_out(j_out), .k_out(k_out),
    .busy(busy), .done(done), .err(err)
`ifdef JK_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  function automatic logic [7:0] cur_err_cnt();
`ifdef JK_ERR_CNT_EN
    return err_cnt;
`else
    return 8'h00;
`endif
  endfunction

  // One request through to its pulse; checks drive cycle, pulse kind/timing, final Q, error count.
  task automatic run_txn(input string tag, input logic [1:0] mode, input logic [7:0] data,
                         input logic [7:0] watch, input logic [7:0] exp_j, input logic [7:0] exp_k,
                         input logic [7:0] exp_q, input bit exp_err, input int exp_cyc,
                         input int exp_fails, output int drv_cnt);
    int n_done, n_err, pulse_cyc, jk_bad, wait_n, sat;
    logic [7:0] cnt0;
    bit finished;
    n_done = 0; n_err = 0; pulse_cyc = 0; jk_bad = 0; wait_n = 0; drv_cnt = 0; finished = 0;
    while (!req_ready && wait_n < 100) begin
      @(negedge clk);
      wait_n++;
    end
    if (!req_ready) begin
      chk({tag, "_ready_timeout"}, 0, 1);
      return;
    end
    cnt0 = cur_err_cnt();
    req_mode  = mode;
    req_data  = data;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_mode  = 2'($urandom);
    req_data  = 8'($urandom);
    for (int c = 1; c <= 200 && !finished; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk({tag, "_j"}, j_out, exp_j);
        chk({tag, "_k"}, k_out, exp_k);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_ready_low"}, req_ready, 0);
      end else if ((j_out & k_out) != 0) begin
        jk_bad++;
      end
      if ((j_out & watch) != 0) drv_cnt++;
      if (done) begin n_done++; if (pulse_cyc == 0) pulse_cyc = c; end
      if (err)  begin n_err++;  if (pulse_cyc == 0) pulse_cyc = c; end
      if (pulse_cyc != 0 && c == pulse_cyc + 1) begin
        chk({tag, "_ready_after"}, req_ready, 1);
        chk({tag, "_busy_after"}, busy, 0);
        finished = 1;
      end
    end
    if (!finished) chk({tag, "_pulse_timeout"}, 0, 1);
    chk({tag, "_pulse_cycle"}, pulse_cyc, exp_cyc);
    chk({tag, "_n_done"}, n_done, exp_err ? 0 : 1);
    chk({tag, "_n_err"}, n_err, exp_err ? 1 : 0);
    chk({tag, "_jk_both"}, jk_bad, 0);
    chk({tag, "_q"}, q_in, exp_q);
`ifdef JK_ERR_CNT_EN
    sat = (int'(cnt0) + exp_fails > 255) ? 255 : int'(cnt0) + exp_fails;
    chk({tag, "_err_cnt"}, err_cnt, sat);
`else
    sat = exp_fails;
`endif
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [7:0] data;
    logic [7:0] stuck;
    logic [7:0] watch;
    logic [7:0] exp_j;
    logic [7:0] exp_k;
    logic [7:0] exp_q;
    bit         exp_err;
    int         exp_cyc;
    int         exp_fails;
    int         exp_drv;
  } vec_t;

  initial begin
    vec_t vecs[5];
    int drv, n_acc, n_done, n_rdy_low, prev_acc;
    logic [1:0] m;
    logic [7:0] d, q0, e, ej, ek;
    bit is_err;

    vecs[0] = '{2'b00, 8'hA5, 8'h00, 8'h00, 8'hA5, 8'h00, 8'hA5, 1'b0, 4, 0, 0};
    vecs[1] = '{2'b01, 8'h0F, 8'h00, 8'h00, 8'h0F, 8'h0F, 8'hAA, 1'b0, 4, 0, 0};
    vecs[2] = '{2'b10, 8'h5A, 8'h00, 8'h00, 8'h00, 8'hAA, 8'h00, 1'b0, 4, 0, 0};
    vecs[3] = '{2'b11, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 1'b0, 4, 0, 0};
    // Bit 2 reads back 0: three drives each with J[2]=1, err at 4+2*(SETTLE+2).
    vecs[4] = '{2'b00, 8'h3C, 8'h04, 8'h04, 8'h04, 8'hC3, 8'h38, 1'b1, 10, 3, 3};

    rst = 1'b1; req_valid = 1'b0; req_mode = 2'b00; req_data = 8'h00;
    #1;
    chk("rst_j", j_out, 0);
    chk("rst_k", k_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_err_cnt", cur_err_cnt(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      stuck = vecs[i].stuck;
      run_txn($sformatf("vec%0d", i), vecs[i].mode, vecs[i].data, vecs[i].watch,
              vecs[i].exp_j, vecs[i].exp_k, vecs[i].exp_q, vecs[i].exp_err,
              vecs[i].exp_cyc, vecs[i].exp_fails, drv);
      if (vecs[i].watch != 0) chk($sformatf("vec%0d_drives", i), drv, vecs[i].exp_drv);
    end
    stuck = 8'h00;
    @(negedge clk);

    // Reset during SETTLE of a load (readback now 3C).
    req_mode = 2'b00; req_data = 8'hF0; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy_before", busy, 1);
    rst = 1'b1;
    req_valid = 1'b1; req_mode = 2'b00; req_data = 8'h55;
    #1;
    chk("mid_j", j_out, 0);
    chk("mid_k", k_out, 0);
    chk("mid_busy", busy, 0);
    chk("mid_ready", req_ready, 1);
    chk("mid_done", done, 0);
    chk("mid_err", err, 0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_wins_busy", busy, 0);
    chk("rst_wins_j", j_out, 0);
    req_valid = 1'b0;
    rst = 1'b0;
    n_done = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done || err) n_done++;
    end
    chk("post_rst_no_pulse", n_done, 0);
    run_txn("after_rst", 2'b00, 8'h01, 8'h00, 8'h01, 8'hF0, 8'h01, 1'b0, 4, 0, drv);

    // Valid held high: one acceptance per IDLE visit, SETTLE+4 cycles apart.
    @(negedge clk);
    req_mode = 2'b11; req_data = 8'h00; req_valid = 1'b1;
    n_acc = 0; n_done = 0; n_rdy_low = 0; prev_acc = -1;
    for (int i = 0; i < 16; i++) begin
      if (i != 0) @(negedge clk);
      if (done) n_done++;
      if (req_ready) begin
        if (prev_acc >= 0) chk("held_gap", i - prev_acc, SETTLE + 4);
        prev_acc = i;
        n_acc++;
      end else begin
        n_rdy_low++;
        chk("held_busy_while_not_ready", busy, 1);
      end
    end
    @(posedge clk); #1 req_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("held_acceptances", n_acc, 4);
    chk("held_ready_low", n_rdy_low, 12);
    chk("held_done_count", n_done, n_acc);

    // Randomized requests against a transaction-level model.
    for (int t = 0; t < 40; t++) begin
      m = 2'($urandom);
      d = 8'($urandom);
      stuck = ($urandom_range(0, 5) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
      #1;
      q0 = bank & ~stuck;
      case (m)
        2'b00:   e = d;
        2'b01:   e = q0 ^ d;
        2'b10:   e = 8'h00;
        default: e = 8'hFF;
      endcase
      if (m == 2'b01) begin ej = d; ek = d; end
      else begin ej = ~q0 & e; ek = q0 & ~e; end
      is_err = ((e & stuck) != 0);
      run_txn($sformatf("rnd%0d", t), m, d, 8'h00, ej, ek, e & ~stuck, is_err,
              is_err ? SETTLE + 3 + MAX_RETRY * (SETTLE + 2) : SETTLE + 3,
              is_err ? MAX_RETRY + 1 : 0, drv);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
